sel_mux_pipe: RTL and testbench

SEL_MUX_PIPE -- requirements
Module: sel_mux_pipe

---
 rtl/sel_mux_pipe.sv | 128 ++++++++++++
 tb/tb_sel_mux_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sel_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux_pipe
// Description : Selects one of NumIn data inputs by Sel and buffers the
//               result in a 2-entry skid buffer with valid/ready handshakes.
//               Out-of-range selects yield zero data and set sel_err.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_mux_pipe #(
  parameter int DataBit = 32,
  parameter int NumIn   = 8,
  parameter int SelBit  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NumIn*DataBit-1:0] In,
  input  logic [SelBit-1:0]        Sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [DataBit-1:0]       Out,
  output logic                     sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [DataBit-1:0] main_data;
  logic               main_err;
  logic [DataBit-1:0] skid_data;
  logic               skid_err;
  logic [DataBit-1:0] beat_data;
  logic               beat_err;
  logic               accept;
  logic               pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Input select: an unmatched Sel leaves data at zero and flags an error
  always_comb begin
    beat_data = '0;
    beat_err  = 1'b1;
    for (int k = 0; k < NumIn; k++) begin
      if (Sel == SelBit'(k)) begin
        beat_data = In[k*DataBit +: DataBit];
        beat_err  = 1'b0;
      end
    end
  end

  // Occupancy state register; flush empties the buffer like reset does
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy transitions from accept/pop
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = ONE;
      ONE: begin
        if (accept && !pop)      state_nxt = TWO;
        else if (pop && !accept) state_nxt = EMPTY;
        else                     state_nxt = ONE;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Main/skid data registers; cleared on reset and flush so Out reads 0
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= beat_data;
            main_err  <= beat_err;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data <= beat_data;
            main_err  <= beat_err;
          end else if (accept) begin
            skid_data <= beat_data;
            skid_err  <= beat_err;
          end
        end
        TWO: begin
          if (pop) begin
            main_data <= skid_data;
            main_err  <= skid_err;
          end
        end
        default: begin
          main_data <= '0;
          main_err  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake and data outputs come from registered state only (plus reset)
  always_comb begin
    out_valid = (state == ONE) || (state == TWO);
    in_ready  = !reset && (state != TWO);
    Out       = main_data;
    sel_err   = main_err;
  end

endmodule
`default_nettype wire

// File: tb/tb_sel_mux_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_mux_pipe
// Description : Self-checking bench for sel_mux_pipe. Drives an 8-input and a
//               6-input instance with shared stimulus; checks a directed
//               vector table, hand-written corner sequences and a random
//               stream against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_mux_pipe;

  typedef struct {
    logic [31:0] d8;
    logic        e8;
    logic [31:0] d6;
    logic        e6;
  } beat_t;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        iv;
    int          sel;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [31:0] out;
    logic        err;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [2:0]   sel_s;
  logic [255:0] in_bus;
  logic [31:0]  out8, out6;
  logic         err8, err6;
  logic         ov8, ov6;
  logic         ir8, ir6;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  beat_t hold;
  vec_t  tbl[20];

  sel_mux_pipe #(.DataBit(32), .NumIn(8), .SelBit(3)) dut (
    .clk(clk), .reset(reset), .In(in_bus), .Sel(sel_s),
    .in_valid(in_valid), .in_ready(ir8), .flush(flush),
    .Out(out8), .sel_err(err8), .out_valid(ov8), .out_ready(out_ready)
  );

  sel_mux_pipe #(.DataBit(32), .NumIn(6), .SelBit(3)) dut6 (
    .clk(clk), .reset(reset), .In(in_bus[191:0]), .Sel(sel_s),
    .in_valid(in_valid), .in_ready(ir6), .flush(flush),
    .Out(out6), .sel_err(err6), .out_valid(ov6), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int sel);
    beat_t b;
    b.d8 = in_bus[32*sel +: 32];
    b.e8 = 1'b0;
    b.d6 = (sel < 6) ? in_bus[32*sel +: 32] : 32'h0;
    b.e6 = (sel >= 6);
    return b;
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare after it
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input int sel, input logic ordy);
    logic  acc, pp;
    beat_t b;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    sel_s     = 3'(sel);
    out_ready = ordy;
    acc = iv && !rst && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    b   = mk(sel);
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
      hold = '{d8: 32'h0, e8: 1'b0, d6: 32'h0, e6: 1'b0};
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    if (q.size() > 0) hold = q[0];
    #1;
    chk("out_valid8", 32'(ov8), 32'(q.size() > 0));
    chk("out_valid6", 32'(ov6), 32'(q.size() > 0));
    chk("in_ready8",  32'(ir8), 32'(!rst && (q.size() < 2)));
    chk("in_ready6",  32'(ir6), 32'(!rst && (q.size() < 2)));
    chk("out8",       out8,     hold.d8);
    chk("err8",       32'(err8), 32'(hold.e8));
    chk("out6",       out6,     hold.d6);
    chk("err6",       32'(err6), 32'(hold.e6));
  endtask

  function automatic vec_t mv(input logic rst, input logic fl, input logic iv, input int sel,
                              input logic ordy, input logic ov, input logic ir,
                              input logic [31:0] out, input logic err);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.sel = sel; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.out = out; v.err = err;
    return v;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel_s = 3'd0;
    hold = '{d8: 32'h0, e8: 1'b0, d6: 32'h0, e6: 1'b0};
    for (int k = 0; k < 8; k++) in_bus[32*k +: 32] = 32'h1000_0000 + k;

    // Directed table for the 8-input instance (expectations after the edge)
    tbl[0] = mv(1, 0, 0, 0, 1, 0, 0, 32'h0, 0);              // reset
    tbl[1] = mv(0, 0, 1, 5, 1, 1, 1, 32'h1000_0005, 0);      // single beat
    tbl[2] = mv(0, 0, 0, 0, 1, 0, 1, 32'h1000_0005, 0);      // popped, retained
    tbl[3] = mv(0, 0, 1, 1, 0, 1, 1, 32'h1000_0001, 0);      // stalled: ONE
    tbl[4] = mv(0, 0, 1, 2, 0, 1, 0, 32'h1000_0001, 0);      // TWO
    tbl[5] = mv(0, 0, 1, 3, 0, 1, 0, 32'h1000_0001, 0);      // offered, refused
    tbl[6] = mv(0, 0, 1, 3, 1, 1, 1, 32'h1000_0002, 0);      // pop from TWO
    tbl[7] = mv(0, 0, 1, 3, 1, 1, 1, 32'h1000_0003, 0);      // accept+pop in ONE
    tbl[8] = mv(0, 0, 0, 0, 1, 0, 1, 32'h1000_0003, 0);      // drained
    for (int i = 0; i < 10; i++)
      tbl[9+i] = mv(0, 0, 1, i % 8, 1, 1, 1, 32'h1000_0000 + 32'(i % 8), 0);
    tbl[19] = mv(0, 0, 0, 0, 1, 0, 1, 32'h1000_0001, 0);

    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].sel, tbl[i].ordy);
      chk($sformatf("tbl%0d.out_valid", i), 32'(ov8),  32'(tbl[i].ov));
      chk($sformatf("tbl%0d.in_ready", i),  32'(ir8),  32'(tbl[i].ir));
      chk($sformatf("tbl%0d.out", i),       out8,      tbl[i].out);
      chk($sformatf("tbl%0d.sel_err", i),   32'(err8), 32'(tbl[i].err));
    end

    // Out-of-range select on the 6-input instance
    cycle(0, 0, 1, 3, 1);
    chk("oor.prev_out6", out6, 32'h1000_0003);
    cycle(0, 0, 1, 7, 1);
    chk("oor.out6", out6, 32'h0);
    chk("oor.err6", 32'(err6), 32'h1);
    chk("oor.valid6", 32'(ov6), 32'h1);
    cycle(0, 0, 0, 0, 1);
    chk("oor.valid6_gone", 32'(ov6), 32'h0);

    // Flush while TWO with a simultaneous offer and pop
    cycle(0, 0, 1, 2, 0);
    cycle(0, 0, 1, 4, 0);
    chk("flush.pre_ready", 32'(ir8), 32'h0);
    cycle(0, 1, 1, 6, 1);
    chk("flush.valid", 32'(ov8), 32'h0);
    chk("flush.out", out8, 32'h0);
    chk("flush.ready", 32'(ir8), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1);
      chk("flush.no_ghost", 32'(ov8), 32'h0);
    end

    // Reset while TWO
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 7, 0);
    cycle(1, 0, 1, 3, 1);
    chk("rst2.valid", 32'(ov8), 32'h0);
    chk("rst2.out", out8, 32'h0);
    chk("rst2.err6", 32'(err6), 32'h0);
    chk("rst2.ready_in_reset", 32'(ir8), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst2.ready_after", 32'(ir8), 32'h1);
    cycle(0, 0, 0, 0, 1);
    chk("rst2.stay_empty", 32'(ov8), 32'h0);

    // Randomized stream against the model
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 8; k++) in_bus[32*k +: 32] = $urandom;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
            ($urandom_range(0, 9) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
